// File: rtl/vram_arbiter.sv
// Arbitrates the single-port VRAM between CPU byte accesses and a sequential line fetcher feeding an FWFT pixel FIFO.
// Every access is ISSUE then CAPTURE (2 cycles); fetch refill is throttled by FIFO occupancy plus the in-flight fetch.
module vram_arbiter #(
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WATER  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        line_start,
    input  logic [15:0] line_base,
    input  logic [9:0]  line_len,
    input  logic        pix_pop,
    output logic        pix_valid,
    output logic [7:0]  pix_data,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        ram_we
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = CW + 1;
    localparam logic [LW-1:0] DEPTH_LVL = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LOW_LVL   = CW'(LOW_WATER);

    typedef enum logic [2:0] {
        IDLE,
        CPU_ISSUE,
        CPU_CAPTURE,
        FETCH_ISSUE,
        FETCH_CAPTURE
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    ram_addr_q, ram_addr_d;
    logic [7:0]     ram_wdata_q, ram_wdata_d;
    logic           ram_we_q, ram_we_d;
    logic           op_we_q, op_we_d;
    logic [7:0]     cpu_rdata_q, cpu_rdata_d;
    logic [15:0]    base_q, base_d;
    logic [15:0]    offset_q, offset_d;
    logic [9:0]     remaining_q, remaining_d;
    logic           active_q, active_d;
    logic           drop_q, drop_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [7:0]     mem_q [FIFO_DEPTH];

    logic           fetch_cap;
    logic           push;
    logic           pop;
    logic           eff_active;
    logic [9:0]     eff_rem;
    logic [CW-1:0]  eff_count;
    logic           eff_inflight;
    logic [15:0]    eff_base;
    logic [15:0]    eff_offset;
    logic [LW-1:0]  level;
    logic           fetch_ok;
    logic           fetch_urgent;
    logic           cpu_ok;

    assign cpu_ack   = (state_q == CPU_CAPTURE);
    assign cpu_rdata = cpu_rdata_d;
    assign pix_valid = (count_q != '0);
    assign pix_data  = pix_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;

    always_comb begin
        fetch_cap = (state_q == FETCH_CAPTURE);
        // A capture is discarded when its line was restarted under it, either now or during its ISSUE.
        push      = fetch_cap && !drop_q && !line_start;
        pop       = pix_pop && (count_q != '0) && !line_start;

        // Grant sees the line as it will be after a same-cycle restart, so the new line can be fetched at once.
        eff_active   = line_start ? (line_len != 10'd0) : active_q;
        eff_rem      = line_start ? line_len : remaining_q;
        eff_count    = line_start ? '0 : count_q;
        eff_inflight = push;
        eff_base     = line_start ? line_base : base_q;
        eff_offset   = line_start ? 16'h0000 : offset_q;
        level        = {1'b0, eff_count} + LW'(eff_inflight);

        fetch_ok     = eff_active && (eff_rem != 10'd0) && (level < DEPTH_LVL);
        fetch_urgent = fetch_ok && (eff_count < LOW_LVL);
        cpu_ok       = cpu_req && !cpu_ack;

        state_d     = state_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        op_we_d     = op_we_q;
        cpu_rdata_d = (cpu_ack && !op_we_q) ? ram_rdata : cpu_rdata_q;

        case (state_q)
            CPU_ISSUE:   state_d = CPU_CAPTURE;
            FETCH_ISSUE: state_d = FETCH_CAPTURE;
            default: begin
                if (fetch_urgent || (fetch_ok && !cpu_ok)) begin
                    state_d    = FETCH_ISSUE;
                    ram_addr_d = eff_base + eff_offset;
                end else if (cpu_ok) begin
                    state_d     = CPU_ISSUE;
                    ram_addr_d  = cpu_addr;
                    ram_wdata_d = cpu_wdata;
                    ram_we_d    = cpu_we;
                    op_we_d     = cpu_we;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        base_d      = base_q;
        offset_d    = offset_q;
        remaining_d = remaining_q;
        active_d    = active_q;
        drop_d      = line_start && (state_q == FETCH_ISSUE);
        if (line_start) begin
            base_d      = line_base;
            offset_d    = 16'h0000;
            remaining_d = line_len;
            active_d    = (line_len != 10'd0);
        end else if (state_q == FETCH_ISSUE) begin
            offset_d    = offset_q + 16'd1;
            remaining_d = remaining_q - 10'd1;
            active_d    = (remaining_q != 10'd1);
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (line_start) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d  = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ram_addr_q  <= 16'h0000;
            ram_wdata_q <= 8'h00;
            ram_we_q    <= 1'b0;
            op_we_q     <= 1'b0;
            cpu_rdata_q <= 8'h00;
            base_q      <= 16'h0000;
            offset_q    <= 16'h0000;
            remaining_q <= 10'd0;
            active_q    <= 1'b0;
            drop_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            op_we_q     <= op_we_d;
            cpu_rdata_q <= cpu_rdata_d;
            base_q      <= base_d;
            offset_q    <= offset_d;
            remaining_q <= remaining_d;
            active_q    <= active_d;
            drop_q      <= drop_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a banked VRAM model; a negedge monitor scores CPU acks and pixel pops against queues.
module tb_vram_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        line_start;
    logic [15:0] line_base;
    logic [9:0]  line_len;
    logic        pix_pop;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        ram_we;

    vram_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .line_start (line_start),
        .line_base  (line_base),
        .line_len   (line_len),
        .pix_pop    (pix_pop),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_we     (ram_we)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // VRAM model: two banks read every cycle, output mux follows the live address MSB.
    logic [7:0] ram_lo [32768];
    logic [7:0] ram_hi [32768];
    logic [7:0] rd_lo, rd_hi;
    always @(posedge clk) begin
        if (ram_we) begin
            if (ram_addr[15]) ram_hi[ram_addr[14:0]] <= ram_wdata;
            else              ram_lo[ram_addr[14:0]] <= ram_wdata;
        end
        rd_lo <= ram_lo[ram_addr[14:0]];
        rd_hi <= ram_hi[ram_addr[14:0]];
    end
    assign ram_rdata = ram_addr[15] ? rd_hi : rd_lo;

    int          vectors = 0;
    int          errors  = 0;
    logic [7:0]  pix_q[$];
    logic        cpu_we_q[$];
    logic [7:0]  cpu_exp_q[$];
    logic [15:0] addr_log[$];
    logic        log_en = 1'b0;
    int          we_cycles = 0;
    logic [15:0] we_addr = 16'h0;
    logic [7:0]  we_data = 8'h0;
    int          fetch_issues = 0;
    int          ff_seen = 0;
    int          ack_count = 0;
    logic [15:0] win_base = 16'hFFFF;
    logic [15:0] win_len = 16'd0;
    logic [15:0] prev_addr = 16'h0;
    logic        prev_fetch = 1'b0;
    logic        is_f;
    int          lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic in_window(input logic [15:0] a);
        logic [15:0] d;
        d = a - win_base;
        return d < win_len;
    endfunction

    always @(negedge clk) begin
        if (ram_we) begin
            we_cycles++;
            we_addr = ram_addr;
            we_data = ram_wdata;
        end
        if (ram_addr != prev_addr) begin
            is_f = in_window(ram_addr);
            if (is_f) fetch_issues++;
            if (is_f && prev_fetch && cpu_req) ff_seen++;
            if (log_en) addr_log.push_back(ram_addr);
            prev_fetch = is_f;
            prev_addr  = ram_addr;
        end
        if (cpu_ack) begin
            ack_count++;
            if (cpu_we_q.size() == 0) begin
                chk("cpu_ack_unexpected", {31'd0, cpu_ack}, 32'd0);
            end else begin
                logic       w;
                logic [7:0] e;
                w = cpu_we_q.pop_front();
                e = cpu_exp_q.pop_front();
                if (!w) chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e});
            end
        end
        if (pix_valid && pix_pop) begin
            if (pix_q.size() == 0) chk("pix_unexpected", {24'd0, pix_data}, 32'hFFFF_FFFF);
            else chk("pix_data", {24'd0, pix_data}, {24'd0, pix_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_op(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                          input logic [7:0] exp, output int latency);
        cpu_we_q.push_back(we);
        cpu_exp_q.push_back(exp);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        latency = 0;
        while (latency < 200) begin
            tick();
            latency++;
            if (cpu_ack) break;
        end
        chk("cpu_ack_seen", {31'd0, cpu_ack}, 32'd1);
        cpu_req = 1'b0;
    endtask

    task automatic start_line(input logic [15:0] base, input logic [9:0] len);
        pix_q.delete();
        for (int i = 0; i < int'(len); i++) pix_q.push_back(8'(base + 16'(i)));
        win_base     = base;
        win_len      = (len == 10'd0) ? 16'd1 : {6'd0, len};
        fetch_issues = 0;
        line_base    = base;
        line_len     = len;
        line_start   = 1'b1;
        tick();
        line_start   = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && pix_q.size() != 0; i++) tick();
        chk(name, pix_q.size(), 0);
        repeat (10) tick();
        chk({name, "_empty"}, {31'd0, pix_valid}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            ram_lo[i[14:0]] = 8'(i);
            ram_hi[i[14:0]] = 8'(i);
        end
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
        line_start = 1'b0; line_base = 16'h0; line_len = 10'd0; pix_pop = 1'b0;
        repeat (3) tick();
        chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
        chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        chk("rst_pix_data", {24'd0, pix_data}, 32'd0);
        chk("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        reset = 1'b0;
        tick();

        // CPU write then read-back, no line active
        we_cycles = 0;
        cpu_op(1'b1, 16'h8001, 8'hA5, 8'h00, lat);
        chk("wr_latency", lat, 2);
        tick(); tick();
        chk("wr_we_cycles", we_cycles, 1);
        chk("wr_we_addr", {16'd0, we_addr}, 32'h8001);
        chk("wr_we_data", {24'd0, we_data}, 32'hA5);
        chk("wr_rdata_unchanged", {24'd0, cpu_rdata}, 32'h00);
        cpu_op(1'b0, 16'h8001, 8'h00, 8'hA5, lat);
        chk("rd_latency", lat, 2);
        repeat (3) tick();
        chk("rd_rdata_held", {24'd0, cpu_rdata}, 32'hA5);

        // Basic line, pop held high
        pix_pop = 1'b1;
        start_line(16'h1000, 10'd8);
        drain("line8_drain");
        chk("line8_issues", fetch_issues, 8);

        // Address wrap across the bank boundary
        addr_log.delete();
        log_en = 1'b1;
        start_line(16'hFFFE, 10'd4);
        drain("wrap_drain");
        log_en = 1'b0;
        chk("wrap_log_len", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            chk("wrap_addr0", {16'd0, addr_log[0]}, 32'hFFFE);
            chk("wrap_addr1", {16'd0, addr_log[1]}, 32'hFFFF);
            chk("wrap_addr2", {16'd0, addr_log[2]}, 32'h0000);
            chk("wrap_addr3", {16'd0, addr_log[3]}, 32'h0001);
        end

        // Fill with CPU contention and no pops: fetch must stop at FIFO_DEPTH
        pix_pop = 1'b0;
        start_line(16'h2000, 10'd32);
        for (int i = 0; i < 40; i++) cpu_op(1'b0, 16'h8001, 8'h00, 8'hA5, lat);
        chk("fill_issues", fetch_issues, 16);
        chk("fill_valid", {31'd0, pix_valid}, 32'd1);

        // Pop while CPU pending: below low water fetch is granted back-to-back ahead of CPU
        ff_seen = 0;
        pix_pop = 1'b1;
        for (int i = 0; i < 30; i++) cpu_op(1'b0, 16'h8001, 8'h00, 8'hA5, lat);
        chk("lowwater_fetch_first", {31'd0, ff_seen > 0}, 32'd1);
        drain("fill_drain");
        chk("fill_total_issues", fetch_issues, 32);

        // line_start during a FETCH_CAPTURE
        pix_pop = 1'b0;
        start_line(16'h3000, 10'd8);
        for (int i = 0; i < 50 && ram_addr != 16'h3002; i++) tick();
        chk("sync_issue_3002", {16'd0, ram_addr}, 32'h3002);
        tick();
        start_line(16'h5010, 10'd3);
        chk("restart_flushed", {31'd0, pix_valid}, 32'd0);
        pix_pop = 1'b1;
        drain("restart_drain");
        chk("restart_issues", fetch_issues, 3);

        // Zero-length line stays inactive
        start_line(16'h6000, 10'd0);
        repeat (20) tick();
        chk("len0_valid", {31'd0, pix_valid}, 32'd0);
        chk("len0_issues", fetch_issues, 0);

        // Reset in the ISSUE cycle of a CPU write: no ack may follow
        pix_pop = 1'b0;
        ack_count = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h7000; cpu_wdata = 8'h5A;
        tick();
        chk("midrst_issue_we", {31'd0, ram_we}, 32'd1);
        reset = 1'b1;
        cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("midrst_no_ack", ack_count, 0);
        chk("midrst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("midrst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Sits directly upstream of the 64KB byte-wide VRAM, which has a single port, synchronous writes and 1-cycle registered reads.
- Arbitrates between two sources: CPU byte accesses over a req/ack handshake, and a video line fetcher that streams sequential bytes into a small FWFT FIFO for the pixel pipeline.
- The VRAM's output bank mux follows the live address MSB, so ram_addr is held stable through the read capture cycle.

Parameters:
FIFO_DEPTH, 16, pixel FIFO entries; power of two, 4..64
LOW_WATER, 4, FIFO level below which fetch outranks CPU

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  16  CPU byte address; stable while cpu_req
cpu_wdata  in  8  CPU write data; stable while cpu_req
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  8  read data; valid in cpu_ack cycle, held until next read completes
line_start  in  1  pulse: latch line_base/line_len, flush FIFO, begin line
line_base  in  16  first byte address of line
line_len  in  10  bytes to fetch (0 = none)
pix_pop  in  1  consume FIFO head
pix_valid  out  1  FIFO non-empty
pix_data  out  8  FIFO head (first-word fall-through)
ram_addr  out  16  to VRAM addr
ram_wdata  out  8  to VRAM data_in
ram_rdata  in  8  from VRAM data_out
ram_we  out  1  to VRAM write_enable

Behaviour:
- Reset: state IDLE, FIFO empty, line inactive, remaining=0. Outputs: cpu_ack=0, cpu_rdata=0, pix_valid=0, pix_data=0, ram_addr=0, ram_wdata=0, ram_we=0.
- Every access takes 2 cycles: ISSUE drives ram_addr; CAPTURE holds ram_addr unchanged and registers ram_rdata. ram_we=1 only in ISSUE of a CPU write. Peak bandwidth is one access per 2 clocks.
- States: IDLE, CPU_ISSUE, CPU_CAPTURE, FETCH_ISSUE, FETCH_CAPTURE. ISSUE always goes to CAPTURE. CAPTURE goes to IDLE, or straight to the next ISSUE when the grant decision below selects one.
- Grant decision, evaluated in IDLE and in the last CAPTURE cycle, first match wins:
  - Fetch, if line active, remaining>0, occupancy+inflight<DEPTH and occupancy<LOW_WATER.
  - CPU, if cpu_req and cpu_ack is not being asserted this cycle.
  - Fetch, if line active, remaining>0 and occupancy+inflight<DEPTH.
  - Otherwise IDLE.
- CPU completion:
  - cpu_ack pulses in the CPU_CAPTURE cycle.
  - For reads, cpu_rdata updates in that same cycle with ram_rdata. For writes, cpu_rdata is unchanged.
  - CPU latency from grant to ack is 2 cycles.
  - A request still asserted in the ack cycle is not regranted that cycle.
- Fetch:
  - Address = line_base + offset, mod 2^16 (wraps 0xFFFF→0x0000).
  - Offset increments on each FETCH_ISSUE. remaining decrements on each FETCH_ISSUE; the line goes inactive at 0.
  - The FETCH_CAPTURE byte is pushed into the FIFO in that cycle and is visible at pix_valid the next cycle.
- FIFO:
  - Push and pop in the same cycle leave the count unchanged.
  - pix_pop while empty is ignored.
  - Overflow cannot occur, because the occupancy+inflight check gates every fetch.
- line_start:
  - Flushes the FIFO (pix_valid=0 next cycle), loads the base, sets remaining=line_len and offset=0.
  - A FETCH_CAPTURE in the same cycle is discarded, not pushed.
  - An in-flight CPU access completes normally.
  - line_len=0 leaves the line inactive.
- Reset mid-access: the access is abandoned, and no cpu_ack is issued afterwards.

Test Plan:
- CPU write 0xA5 to 0x8001, then read it back with no line active → ram_we high exactly 1 cycle with ram_addr=0x8001; read ack 2 cycles after grant, cpu_rdata=0xA5.
- line_start with base 0x1000, len 8, RAM preloaded with addr[7:0], pix_pop held high → pix_data sequence 0x00..0x07, then pix_valid=0; exactly 8 FETCH_ISSUEs.
- Base 0xFFFE, len 4 → fetch addresses FFFE, FFFF, 0000, 0001; the bank switches correctly on the 0xFFFF→0x0000 wrap.
- Continuous cpu_req plus line len 32, pix_pop never asserted → FIFO fills to 16 and fetching stops; CPU is granted whenever occupancy≥4; no overflow.
- Pop down to 3 entries while cpu_req is pending → the next grant goes to fetch ahead of CPU.
- line_start in the same cycle as a FETCH_CAPTURE → the captured byte is dropped, the FIFO is empty next cycle, and the first pushed byte comes from the new base.
